// File: rtl/fifo_flags.sv
// Synchronous first-word-fall-through FIFO with full/empty, programmable
// almost-full/almost-empty thresholds, fill level, sticky overflow and flush.
module fifo_flags #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    localparam int LW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_d_rdy,
    input  logic             rdy2rcv,
    input  logic             flush,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_d_rdy,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [LW-1:0]    level,
    output logic             ovf
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             pop;
    logic             accept;
    logic             drop;

    assign empty        = (level == '0);
    assign full         = (level == LW'(DEPTH));
    assign almost_full  = (int'(level) >= AF_LEVEL);
    assign almost_empty = (int'(level) <= AE_LEVEL);

    assign out_d_rdy = !empty && rdy2rcv;
    assign out_data  = out_d_rdy ? mem[rptr] : '0;

    // A full FIFO still accepts a write when the head word leaves in the same cycle.
    assign pop    = out_d_rdy && !flush;
    assign accept = in_d_rdy && (!full || out_d_rdy) && !flush;
    assign drop   = in_d_rdy && full && !out_d_rdy && !flush;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr] <= in_data;
        end
    end

    // Explicit wrap at DEPTH-1 keeps non-power-of-two depths correct.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (accept) begin
                wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
            end
            if (pop) begin
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
            end
            if (accept && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !accept) begin
                level <= level - LW'(1);
            end
        end
    end

    // Set beats clear when a write is dropped in the same cycle as ovf_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule
